// File: rtl/fb_capture_pkg.sv
// Shared types and geometry for the camera capture path and the VGA output stage.
package fb_capture_pkg;

  localparam int SRC_WIDTH  = 640;
  localparam int SRC_HEIGHT = 480;
  localparam int FB_WIDTH   = 320;
  localparam int FB_HEIGHT  = 240;
  localparam int FB_DEPTH   = 76800;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_FRAME_END = 2'd3
  } captureState_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel888_t;

endpackage

// File: rtl/rgb565_to_rgb888.sv
// Combinational RGB565 -> RGB888 expander; low bits replicate the MSBs so full scale maps to 0xFF.
module rgb565_to_rgb888
  import fb_capture_pkg::*;
(
  input  logic [15:0] rgb565,
  output pixel888_t   rgb888
);

  assign rgb888.red   = {rgb565[15:11], rgb565[15:13]};
  assign rgb888.green = {rgb565[10:5],  rgb565[10:9]};
  assign rgb888.blue  = {rgb565[4:0],   rgb565[4:2]};

endmodule

// File: rtl/fb_capture_writer.sv
// Captures RGB565 camera frames, decimates 2:1 in both axes and writes RGB888 into the frame buffer.
// Handshake: VSync/HRef/Data are acted on only in cycles where ByteValid=1; there is no back-pressure.
module fb_capture_writer #(
  parameter int SRC_WIDTH  = fb_capture_pkg::SRC_WIDTH,
  parameter int SRC_HEIGHT = fb_capture_pkg::SRC_HEIGHT,
  parameter int FB_WIDTH   = fb_capture_pkg::FB_WIDTH
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset_n,
  input  logic        piul1Enable,
  input  logic        piul1ByteValid,
  input  logic        piul1VSync,
  input  logic        piul1HRef,
  input  logic [7:0]  piul8Data,
  output logic        poul1WriteEnable,
  output logic [16:0] poul17WriteAddress,
  output logic [23:0] poul24WriteData,
  output logic        poul1FrameDone,
  output logic        poul1FrameError,
  output logic        poul1Busy,
  output logic [1:0]  poul2State
);

  fb_capture_pkg::captureState_t state;
  fb_capture_pkg::pixel888_t     pixel888;

  logic        prevVSync, prevHRef, bytePhase, errorFlag;
  logic [7:0]  firstByte;
  logic [9:0]  col;
  logic [8:0]  row;
  logic [16:0] rowBase;
  logic        vsRise, vsFall, hrRise, hrFall, rowFull, colFull;

  // Edges are measured against the previous valid sample, not the previous clock.
  assign vsRise  = piul1ByteValid &&  piul1VSync && !prevVSync;
  assign vsFall  = piul1ByteValid && !piul1VSync &&  prevVSync;
  assign hrRise  = piul1ByteValid &&  piul1HRef  && !prevHRef;
  assign hrFall  = piul1ByteValid && !piul1HRef  &&  prevHRef;
  assign rowFull = (row == 9'(SRC_HEIGHT));
  assign colFull = (col == 10'(SRC_WIDTH));

  rgb565_to_rgb888 uExpand (
    .rgb565 ({firstByte, piul8Data}),
    .rgb888 (pixel888)
  );

  assign poul1Busy  = (state == fb_capture_pkg::ST_WAIT_LINE) || (state == fb_capture_pkg::ST_CAPTURE);
  assign poul2State = state;

  always_ff @(posedge piul1Clock) begin
    if (!piul1Reset_n) begin
      state              <= fb_capture_pkg::ST_IDLE;
      prevVSync          <= 1'b0;
      prevHRef           <= 1'b0;
      bytePhase          <= 1'b0;
      errorFlag          <= 1'b0;
      firstByte          <= 8'd0;
      col                <= 10'd0;
      row                <= 9'd0;
      rowBase            <= 17'd0;
      poul1WriteEnable   <= 1'b0;
      poul17WriteAddress <= 17'd0;
      poul24WriteData    <= 24'd0;
      poul1FrameDone     <= 1'b0;
      poul1FrameError    <= 1'b0;
    end else begin
      poul1WriteEnable <= 1'b0;
      poul1FrameDone   <= 1'b0;
      poul1FrameError  <= 1'b0;
      if (piul1ByteValid) begin
        prevVSync <= piul1VSync;
        prevHRef  <= piul1HRef;
      end
      case (state)
        fb_capture_pkg::ST_IDLE: begin
          if (vsFall && piul1Enable) begin
            state     <= fb_capture_pkg::ST_WAIT_LINE;
            row       <= 9'd0;
            col       <= 10'd0;
            rowBase   <= 17'd0;
            bytePhase <= 1'b0;
            errorFlag <= 1'b0;
          end
        end
        fb_capture_pkg::ST_WAIT_LINE, fb_capture_pkg::ST_CAPTURE: begin
          if (vsRise) begin
            // Done/Error registered here so they coincide with the FRAME_END cycle.
            state           <= fb_capture_pkg::ST_FRAME_END;
            poul1FrameDone  <= 1'b1;
            poul1FrameError <= errorFlag || !rowFull || (state == fb_capture_pkg::ST_CAPTURE);
          end else if (state == fb_capture_pkg::ST_WAIT_LINE) begin
            if (hrRise && !piul1VSync) begin
              state     <= fb_capture_pkg::ST_CAPTURE;
              col       <= 10'd0;
              bytePhase <= 1'b1;
              firstByte <= piul8Data;
              if (rowFull) errorFlag <= 1'b1;
            end
          end else if (hrFall) begin
            state     <= fb_capture_pkg::ST_WAIT_LINE;
            bytePhase <= 1'b0;
            if (bytePhase || !colFull) errorFlag <= 1'b1;
            if (!rowFull) begin
              row <= row + 9'd1;
              if (!row[0]) rowBase <= rowBase + 17'(FB_WIDTH);
            end
          end else if (piul1ByteValid && piul1HRef) begin
            if (!bytePhase) begin
              firstByte <= piul8Data;
              bytePhase <= 1'b1;
            end else begin
              bytePhase <= 1'b0;
              if (colFull || rowFull) begin
                errorFlag <= 1'b1;
              end else begin
                col <= col + 10'd1;
                if (!col[0] && !row[0]) begin
                  poul1WriteEnable   <= 1'b1;
                  poul17WriteAddress <= rowBase + 17'(col[9:1]);
                  poul24WriteData    <= pixel888;
                end
              end
            end
          end
        end
        fb_capture_pkg::ST_FRAME_END: begin
          errorFlag <= 1'b0;
          state     <= fb_capture_pkg::ST_IDLE;
        end
        default: state <= fb_capture_pkg::ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_capture_writer.sv
// Directed bench for fb_capture_writer: expected writes queued from a geometry model, frame pulses counted.
module tb_fb_capture_writer;
  import fb_capture_pkg::*;

  // Frame height reduced so a complete frame stays short; line width and buffer pitch are full size.
  localparam int TB_WIDTH  = 640;
  localparam int TB_HEIGHT = 8;
  localparam int TB_FBW    = 320;

  logic        clk = 1'b0;
  logic        rst_n, enable, byte_valid, v_sync, h_ref;
  logic [7:0]  data;
  logic        wr_en, frame_done, frame_error, busy;
  logic [16:0] wr_addr;
  logic [23:0] wr_data;
  logic [1:0]  state_dbg;

  logic [40:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int done_count = 0;
  int err_count = 0;
  bit gap_mode = 1'b0;

  always #5 clk = ~clk;

  fb_capture_writer #(
    .SRC_WIDTH  (TB_WIDTH),
    .SRC_HEIGHT (TB_HEIGHT),
    .FB_WIDTH   (TB_FBW)
  ) dut (
    .piul1Clock         (clk),
    .piul1Reset_n       (rst_n),
    .piul1Enable        (enable),
    .piul1ByteValid     (byte_valid),
    .piul1VSync         (v_sync),
    .piul1HRef          (h_ref),
    .piul8Data          (data),
    .poul1WriteEnable   (wr_en),
    .poul17WriteAddress (wr_addr),
    .poul24WriteData    (wr_data),
    .poul1FrameDone     (frame_done),
    .poul1FrameError    (frame_error),
    .poul1Busy          (busy),
    .poul2State         (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  function automatic logic [15:0] pixel_of(input int mode, input int c, input int r);
    if (mode == 0) return 16'hF800;
    return 16'(c * 40503 + r * 7919);
  endfunction

  // One valid byte; in gap mode an invalid cycle carrying junk may precede it.
  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    if (gap_mode && $urandom_range(0, 3) == 0) begin
      byte_valid = 1'b0;
      v_sync     = 1'($urandom_range(0, 1));
      h_ref      = 1'($urandom_range(0, 1));
      data       = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    v_sync     = vs;
    h_ref      = hr;
    data       = d;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] p);
    drive(1'b0, 1'b1, p[15:8]);
    drive(1'b0, 1'b1, p[7:0]);
  endtask

  task automatic frame_start(input logic en);
    enable = en;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic end_line();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int npix, input int mode, input int r, input bit armed);
    logic [15:0] p;
    for (int c = 0; c < npix; c++) begin
      p = pixel_of(mode, c, r);
      if (armed && (r % 2 == 0) && r < TB_HEIGHT && c < TB_WIDTH && (c % 2 == 0))
        exp_q.push_back({17'((r / 2) * TB_FBW + c / 2), expand(p)});
      send_pix(p);
    end
    end_line();
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("write_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
      check("addr_in_range", 64'(wr_addr < 17'(FB_DEPTH)), 64'd1);
    end
    if (frame_done) done_count++;
    if (frame_error) begin
      err_count++;
      check("error_with_done", 64'(frame_done), 64'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; byte_valid = 1'b0;
    v_sync = 1'b0; h_ref = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_we",    64'(wr_en),       64'd0);
    check("reset_addr",  64'(wr_addr),     64'd0);
    check("reset_data",  64'(wr_data),     64'd0);
    check("reset_done",  64'(frame_done),  64'd0);
    check("reset_error", 64'(frame_error), 64'd0);
    check("reset_busy",  64'(busy),        64'd0);
    check("reset_state", 64'(state_dbg),   64'(ST_IDLE));
    rst_n = 1'b1;
    gap_mode = 1'b1;

    // Reset mid-line after byte 0 of the second pixel.
    frame_start(1'b1);
    check("armed_busy", 64'(busy), 64'd1);
    exp_q.push_back({17'd0, 24'hFF0000});
    send_pix(16'hF800);
    drive(1'b0, 1'b1, 8'hF8);
    check("capture_state", 64'(state_dbg), 64'(ST_CAPTURE));
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    check("midreset_we",    64'(wr_en),     64'd0);
    check("midreset_addr",  64'(wr_addr),   64'd0);
    check("midreset_data",  64'(wr_data),   64'd0);
    check("midreset_busy",  64'(busy),      64'd0);
    check("midreset_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    end_line();
    frame_end();
    check("midreset_no_done", 64'(done_count), 64'd0);
    check("midreset_queue",   64'(exp_q.size()), 64'd0);

    // Complete red frame.
    done_count = 0; err_count = 0;
    frame_start(1'b1);
    for (int r = 0; r < TB_HEIGHT; r++) send_line(TB_WIDTH, 0, r, 1'b1);
    frame_end();
    check("full_done",  64'(done_count),   64'd1);
    check("full_error", 64'(err_count),    64'd0);
    check("full_queue", 64'(exp_q.size()), 64'd0);
    check("full_busy",  64'(busy),         64'd0);

    // Hand-computed pixels on short lines; col 2 / row 2 lands at 321.
    done_count = 0; err_count = 0;
    gap_mode = 1'b0;
    frame_start(1'b1);
    exp_q.push_back({17'd0,   24'h1045A5});
    exp_q.push_back({17'd1,   24'h848284});
    exp_q.push_back({17'd320, 24'h000000});
    exp_q.push_back({17'd321, 24'h00FF00});
    send_pix(16'h1234); send_pix(16'hFFFF); send_pix(16'h8410); end_line();
    send_pix(16'hAAAA); send_pix(16'hAAAA); send_pix(16'hAAAA); end_line();
    send_pix(16'h0000);
    send_pix(16'h5555);
    check("odd_col_no_write", 64'(wr_en), 64'd0);
    send_pix(16'h07E0);
    check("lat_we",   64'(wr_en),   64'd1);
    check("lat_addr", 64'(wr_addr), 64'd321);
    check("lat_data", 64'(wr_data), 64'h00FF00);
    drive(1'b0, 1'b0, 8'h00);
    check("lat_we_drop", 64'(wr_en), 64'd0);
    drive(1'b0, 1'b0, 8'h00);
    frame_end();
    check("directed_done",  64'(done_count),   64'd1);
    check("directed_error", 64'(err_count),    64'd1);
    check("directed_queue", 64'(exp_q.size()), 64'd0);
    gap_mode = 1'b1;

    // Enable low at the VSync falling edge, raised mid-frame.
    done_count = 0; err_count = 0;
    frame_start(1'b0);
    enable = 1'b1;
    send_line(4, 1, 0, 1'b0);
    check("skip_busy", 64'(busy), 64'd0);
    send_line(4, 1, 1, 1'b0);
    frame_end();
    check("skip_done",  64'(done_count),   64'd0);
    check("skip_queue", 64'(exp_q.size()), 64'd0);

    // Over-long line on row 0.
    done_count = 0; err_count = 0;
    frame_start(1'b1);
    send_line(TB_WIDTH + 2, 1, 0, 1'b1);
    frame_end();
    check("long_done",  64'(done_count),   64'd1);
    check("long_error", 64'(err_count),    64'd1);
    check("long_queue", 64'(exp_q.size()), 64'd0);

    // Short frame: VSync rises after half the lines.
    done_count = 0; err_count = 0;
    frame_start(1'b1);
    for (int r = 0; r < TB_HEIGHT / 2; r++) send_line(TB_WIDTH, 1, r, 1'b1);
    frame_end();
    check("short_done",  64'(done_count),   64'd1);
    check("short_error", 64'(err_count),    64'd1);
    check("short_queue", 64'(exp_q.size()), 64'd0);
    check("short_state", 64'(state_dbg),    64'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
